// File: rtl/fetch_stream.sv
// fetch_stream: in-order instruction fetch stage between PC/predictor and decode.
// Latency: a cache response is visible on fetch_o the cycle after it returns.
// Backpressure: credit-limited issue (live entries + owed drops <= DEPTH);
//   fetch_o holds until fetch_o_ready, and fetch_data is always accepted.
// Ports:
//   clk, rstn (sync, active-low)
//   redirect_valid/redirect_pc          flush and restart fetch
//   fetch_addr_valid/ready, fetch_addr  request channel to I-cache
//   fetch_data_valid, fetch_data        in-order cache responses
//   fetch_data_ready                    tied high
//   pred_pc -> pred_pcnext              combinational next-pc prediction
//   fetch_o_valid/ready, fetch_o_pc/data/pnext  entries delivered to decode
module fetch_stream #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_addr_valid,
  input  logic            fetch_addr_ready,
  output logic [XLEN-1:0] fetch_addr,
  input  logic            fetch_data_valid,
  input  logic [ILEN-1:0] fetch_data,
  output logic            fetch_data_ready,
  output logic [XLEN-1:0] pred_pc,
  input  logic [XLEN-1:0] pred_pcnext,
  output logic            fetch_o_valid,
  input  logic            fetch_o_ready,
  output logic [XLEN-1:0] fetch_o_pc,
  output logic [ILEN-1:0] fetch_o_data,
  output logic [XLEN-1:0] fetch_o_pnext
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;             // pointer with wrap bit
  localparam int DW = $clog2(DEPTH + 1);  // drop counter holds 0..DEPTH
  localparam int SW = PW + 1;             // occ + drop_cnt without overflow

  logic [XLEN-1:0] pc_q;
  logic [PW-1:0]   head, fill, tail;
  logic [DW-1:0]   drop_cnt;

  logic [XLEN-1:0] ent_pc   [DEPTH];
  logic [XLEN-1:0] ent_pn   [DEPTH];
  logic [ILEN-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0] ent_filled;

  logic [PW-1:0] occ, pend;
  logic [SW-1:0] credit_sum;
  logic [IW-1:0] head_idx, fill_idx, tail_idx;
  logic          issue, pop, resp_live, resp_drop;
  logic [SW-1:0] redirect_drop;

  assign occ        = tail - head;
  assign pend       = tail - fill;
  assign credit_sum = SW'(occ) + SW'(drop_cnt);
  assign head_idx   = head[IW-1:0];
  assign fill_idx   = fill[IW-1:0];
  assign tail_idx   = tail[IW-1:0];

  // Credits count both live entries and responses still owed for flushed
  // requests, so every response that can arrive has a slot or a drop slot.
  assign fetch_addr_valid = rstn && !redirect_valid && (credit_sum < SW'(DEPTH));
  assign fetch_addr       = pc_q;
  assign pred_pc          = pc_q;
  assign fetch_data_ready = 1'b1;

  assign fetch_o_valid = rstn && !redirect_valid && (occ != '0) && ent_filled[head_idx];
  assign fetch_o_pc    = ent_pc[head_idx];
  assign fetch_o_data  = ent_data[head_idx];
  assign fetch_o_pnext = ent_pn[head_idx];

  assign issue     = fetch_addr_valid && fetch_addr_ready;
  assign pop       = fetch_o_valid && fetch_o_ready;
  assign resp_drop = fetch_data_valid && (drop_cnt != '0);
  assign resp_live = fetch_data_valid && (drop_cnt == '0);

  // A response in the redirect cycle belongs to the old stream: it either
  // consumes one owed drop or one of the pending live entries being flushed.
  assign redirect_drop = SW'(drop_cnt) + SW'(pend) - SW'(fetch_data_valid);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q       <= RESET_PC;
      head       <= '0;
      fill       <= '0;
      tail       <= '0;
      drop_cnt   <= '0;
      ent_filled <= '0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc;
      head       <= tail;
      fill       <= tail;
      drop_cnt   <= DW'(redirect_drop);
      ent_filled <= '0;
    end else begin
      if (issue) begin
        pc_q                 <= pred_pcnext;
        tail                 <= tail + 1'b1;
        ent_filled[tail_idx] <= 1'b0;
      end
      if (resp_drop) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
      if (resp_live) begin
        ent_filled[fill_idx] <= 1'b1;
        fill                 <= fill + 1'b1;
      end
      if (pop) begin
        ent_filled[head_idx] <= 1'b0;
        head                 <= head + 1'b1;
      end
    end
  end

  // Entry payload needs no reset; the filled bits qualify it.
  always_ff @(posedge clk) begin
    if (rstn && !redirect_valid) begin
      if (issue) begin
        ent_pc[tail_idx] <= pc_q;
        ent_pn[tail_idx] <= pred_pcnext;
      end
      if (resp_live) begin
        ent_data[fill_idx] <= fetch_data;
      end
    end
  end

  // A live response with nothing pending means the cache broke ordering.
  always @(posedge clk) begin
    if (rstn && fetch_data_valid) begin
      assert (drop_cnt != '0 || pend != '0);
    end
  end

endmodule

// File: tb/tb_fetch_stream.sv
module tb_fetch_stream;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int DEPTH = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic            clk = 1'b0;
  logic            rstn;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_addr_valid;
  logic            fetch_addr_ready;
  logic [XLEN-1:0] fetch_addr;
  logic            fetch_data_valid;
  logic [ILEN-1:0] fetch_data;
  logic            fetch_data_ready;
  logic [XLEN-1:0] pred_pc;
  logic [XLEN-1:0] pred_pcnext;
  logic            fetch_o_valid;
  logic            fetch_o_ready;
  logic [XLEN-1:0] fetch_o_pc;
  logic [ILEN-1:0] fetch_o_data;
  logic [XLEN-1:0] fetch_o_pnext;

  always #5 clk = ~clk;

  fetch_stream #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rstn(rstn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_addr_valid(fetch_addr_valid), .fetch_addr_ready(fetch_addr_ready),
    .fetch_addr(fetch_addr),
    .fetch_data_valid(fetch_data_valid), .fetch_data(fetch_data),
    .fetch_data_ready(fetch_data_ready),
    .pred_pc(pred_pc), .pred_pcnext(pred_pcnext),
    .fetch_o_valid(fetch_o_valid), .fetch_o_ready(fetch_o_ready),
    .fetch_o_pc(fetch_o_pc), .fetch_o_data(fetch_o_data), .fetch_o_pnext(fetch_o_pnext)
  );

  // Predictor: sequential except one taken branch.
  function automatic logic [63:0] pn_fn(input logic [63:0] pc);
    return (pc == 64'h8000_0014) ? 64'h8000_0040 : pc + 64'd4;
  endfunction
  function automatic logic [31:0] dat_fn(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction
  assign pred_pcnext = pn_fn(pred_pc);

  typedef struct {logic [63:0] pc; logic [63:0] pn; logic [31:0] data; bit filled;} ent_t;
  typedef struct {logic [63:0] addr; int due;} creq_t;

  ent_t  mq[$];           // live fetch entries in program order
  creq_t cq[$];           // every request the cache still owes, in order
  int    m_drop;
  logic [63:0] m_pc;
  bit    mvalid = 1'b0;
  int    cyc = 0;

  bit c_rst, c_rv, c_far, c_for, c_hold;
  logic [63:0] c_rpc;
  int lat = 1;

  logic [63:0] iss_log[$], pop_log[$], popn_log[$];
  bit last_fav, last_fov;
  int drop_seen;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, advance model.
  task automatic step();
    bit dv, e_fav, e_fov;
    int pend;
    @(negedge clk);
    rstn             = !c_rst;
    redirect_valid   = c_rv;
    redirect_pc      = c_rpc;
    fetch_addr_ready = c_far;
    fetch_o_ready    = c_for;
    dv = !c_rst && !c_hold && cq.size() > 0 && cq[0].due <= cyc;
    fetch_data_valid = dv;
    fetch_data       = dv ? dat_fn(cq[0].addr) : 32'h0;
    #1;
    e_fav = !c_rst && !c_rv && (mq.size() + m_drop < DEPTH);
    e_fov = !c_rst && !c_rv && mq.size() > 0 && mq[0].filled;
    chk("fetch_addr_valid", 64'(fetch_addr_valid), 64'(e_fav));
    chk("fetch_o_valid", 64'(fetch_o_valid), 64'(e_fov));
    chk("fetch_data_ready", 64'(fetch_data_ready), 64'd1);
    if (mvalid) begin
      chk("pred_pc", pred_pc, m_pc);
      chk("drop_cnt", 64'(dut.drop_cnt), 64'(m_drop));
      if (e_fav) chk("fetch_addr", fetch_addr, m_pc);
      if (e_fov) begin
        chk("fetch_o_pc", fetch_o_pc, mq[0].pc);
        chk("fetch_o_data", 64'(fetch_o_data), 64'(mq[0].data));
        chk("fetch_o_pnext", fetch_o_pnext, mq[0].pn);
      end
    end
    last_fav = e_fav;
    last_fov = e_fov;
    if (c_rst) begin
      mq.delete(); cq.delete();
      m_drop = 0; m_pc = RESET_PC; mvalid = 1'b1;
    end else begin
      pend = 0;
      foreach (mq[i]) if (!mq[i].filled) pend++;
      if (dv) void'(cq.pop_front());
      if (c_rv) begin
        if (dv) begin
          if (m_drop > 0) begin m_drop--; drop_seen++; end
          else pend--;
        end
        m_drop += pend;
        mq.delete();
        m_pc = c_rpc;
      end else begin
        if (e_fov && c_for) begin
          pop_log.push_back(mq[0].pc);
          popn_log.push_back(mq[0].pn);
          void'(mq.pop_front());
        end
        if (dv) begin
          if (m_drop > 0) begin m_drop--; drop_seen++; end
          else begin
            for (int i = 0; i < mq.size(); i++) begin
              if (!mq[i].filled) begin
                mq[i].data = fetch_data; mq[i].filled = 1'b1; break;
              end
            end
          end
        end
        if (e_fav && c_far) begin
          mq.push_back('{pc: m_pc, pn: pn_fn(m_pc), data: 32'h0, filled: 1'b0});
          cq.push_back('{addr: m_pc, due: cyc + lat});
          iss_log.push_back(m_pc);
          m_pc = pn_fn(m_pc);
        end
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_logs();
    iss_log.delete(); pop_log.delete(); popn_log.delete(); drop_seen = 0;
  endtask

  task automatic do_reset();
    c_rst = 1; c_rv = 0; c_hold = 0; c_far = 1; c_for = 1; lat = 1;
    step();
    c_rst = 0;
    clr_logs();
  endtask

  int n0;

  initial begin
    rstn = 0; redirect_valid = 0; redirect_pc = '0; fetch_addr_ready = 0;
    fetch_o_ready = 0; fetch_data_valid = 0; fetch_data = '0;
    c_rst = 1; c_rv = 0; c_far = 1; c_for = 1; c_hold = 0; c_rpc = '0;
    run(2);
    chk("reset_fav_low", 64'(last_fav), 64'd0);
    do_reset();

    // Stream, 1-cycle cache, decode always ready
    run(12);
    chk("stream_iss0", iss_log[0], 64'h8000_0000);
    chk("stream_iss1", iss_log[1], 64'h8000_0004);
    chk("stream_pop0", pop_log[0], 64'h8000_0000);
    chk("stream_pops", 64'(pop_log.size()), 64'd10);
    chk("stream_br_pc", pop_log[5], 64'h8000_0014);
    chk("stream_br_pn", popn_log[5], 64'h8000_0040);
    chk("stream_tgt_pc", pop_log[6], 64'h8000_0040);

    // Backpressure fills the ring, then drains in order
    do_reset();
    c_for = 0;
    run(10);
    chk("bp_issued", 64'(iss_log.size()), 64'd4);
    chk("bp_last_iss", iss_log[3], 64'h8000_000C);
    chk("bp_stalled", 64'(last_fav), 64'd0);
    c_for = 1;
    run(8);
    chk("bp_pop0", pop_log[0], 64'h8000_0000);
    chk("bp_pop1", pop_log[1], 64'h8000_0004);
    chk("bp_pop2", pop_log[2], 64'h8000_0008);
    chk("bp_pop3", pop_log[3], 64'h8000_000C);
    chk("bp_resume", iss_log[4], 64'h8000_0010);

    // Flush with two responses in flight and one entry filled
    do_reset();
    c_for = 0; c_hold = 1;
    run(3);
    c_far = 0; c_hold = 0;
    run(1);
    c_hold = 1;
    run(1);
    chk("flush_fov_before", 64'(last_fov), 64'd1);
    c_rv = 1; c_rpc = 64'h8000_1000; c_for = 1;
    run(1);
    chk("flush_fov_during", 64'(last_fov), 64'd0);
    chk("flush_drop", 64'(m_drop), 64'd2);
    c_rv = 0; c_hold = 0; c_far = 1;
    run(8);
    chk("flush_dropped", 64'(drop_seen), 64'd2);
    chk("flush_first_pc", pop_log[0], 64'h8000_1000);

    // Redirect coinciding with a response and decode ready
    do_reset();
    lat = 2;
    run(5);
    chk("rr_pops_before", 64'(pop_log.size()), 64'd2);
    c_rv = 1; c_rpc = 64'h8000_2000;
    run(1);
    chk("rr_no_pop", 64'(pop_log.size()), 64'd2);
    chk("rr_drop", 64'(m_drop), 64'd1);
    c_rv = 0;
    run(7);
    chk("rr_first_pc", pop_log[2], 64'h8000_2000);

    // Credit limit with owed drops, then back-to-back redirects
    do_reset();
    c_hold = 1; c_for = 0;
    run(3);
    c_rv = 1; c_rpc = 64'h8000_3000;
    run(1);
    chk("cl_drop3", 64'(m_drop), 64'd3);
    c_rv = 0;
    n0 = iss_log.size();
    run(3);
    chk("cl_stalled", 64'(last_fav), 64'd0);
    chk("cl_one_issue", 64'(iss_log.size()), 64'(n0 + 1));
    for (int k = 0; k < 3; k++) begin
      c_hold = 0; run(1);
      c_hold = 1; run(2);
      chk("cl_reenable", 64'(iss_log.size()), 64'(n0 + 2 + k));
    end
    chk("cl_drop0", 64'(m_drop), 64'd0);
    chk("cl_last_iss", iss_log[iss_log.size()-1], 64'h8000_300C);
    c_rv = 1; c_rpc = 64'h8000_4000;
    run(1);
    c_hold = 0;
    run(1);
    chk("b2b_drop", 64'(m_drop), 64'd3);
    c_rv = 0;
    run(8);
    chk("b2b_drained", 64'(m_drop), 64'd0);

    // Reset mid-stream with three entries held
    do_reset();
    c_for = 0;
    run(3);
    c_far = 0;
    run(2);
    chk("mr_held", 64'(last_fov), 64'd1);
    c_rst = 1;
    run(1);
    c_rst = 0; c_far = 1; c_for = 1;
    clr_logs();
    run(1);
    chk("mr_fov", 64'(last_fov), 64'd0);
    chk("mr_first_addr", iss_log[0], 64'h8000_0000);
    chk("mr_drop", 64'(m_drop), 64'd0);
    run(4);
    chk("mr_first_pop", pop_log[0], 64'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
